// File: rtl/datapath_bus_sequencer.sv
// Multicycle sequencer sharing one memory bus between instruction fetch and load/store.
// Optional BUS_TIMEOUT_EN adds a per-state handshake timeout that sets bus_error and halts.
module datapath_bus_sequencer #(
    parameter logic [31:0] INITIAL_INST = 32'h0000_0013
`ifdef BUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_write_data,
    input  logic        ctl_regfile_write_enable,
    input  logic        ctl_data_mem_read_enable,
    input  logic        ctl_data_mem_write_enable,
    input  logic [2:0]  ctl_data_mem_format,
    output logic [31:0] inst,
    output logic [31:0] data_mem_read_data,
    output logic        pc_write_enable,
    output logic        regfile_write_enable,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_byte_en,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_data,
    output logic        bus_error,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH_REQ,
        FETCH_RESP,
        EXECUTE,
        DATA_REQ,
        DATA_RESP,
        COMMIT
`ifdef BUS_TIMEOUT_EN
        , HALT
`endif
    } state_t;

    state_t state, state_n;
    logic   commit;
    logic   mem_op, is_store, is_load;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        unused_bits;

    // pc[1:0] is always dropped; format[2] only selects sign extension downstream
    assign unused_bits = ^{pc[1:0], ctl_data_mem_format[2]};

    assign mem_op   = ctl_data_mem_read_enable | ctl_data_mem_write_enable;
    assign is_store = ctl_data_mem_write_enable;
    assign is_load  = ctl_data_mem_read_enable & ~ctl_data_mem_write_enable;

    // Misaligned halfword/word accesses are silently force-aligned
    always_comb begin
        data_addr  = {data_mem_address[31:2], 2'b00};
        data_be    = 4'hF;
        data_wdata = data_mem_write_data;
        case (ctl_data_mem_format[1:0])
            2'b00: begin
                data_addr  = data_mem_address;
                data_wdata = {4{data_mem_write_data[7:0]}};
                if (is_store) data_be = 4'b0001 << data_mem_address[1:0];
            end
            2'b01: begin
                data_addr  = {data_mem_address[31:1], 1'b0};
                data_wdata = {2{data_mem_write_data[15:0]}};
                if (is_store) data_be = 4'b0011 << {data_mem_address[1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;
    logic          bus_state;
    logic          err;

    assign bus_state = (state == FETCH_REQ) || (state == FETCH_RESP) ||
                       (state == DATA_REQ)  || (state == DATA_RESP);
`endif

    always_comb begin
        state_n         = state;
        bus_req_valid   = 1'b0;
        bus_req_write   = 1'b0;
        bus_req_addr    = 32'h0;
        bus_req_wdata   = 32'h0;
        bus_req_byte_en = 4'h0;
        commit          = 1'b0;
        case (state)
            FETCH_REQ: begin
                bus_req_valid   = 1'b1;
                bus_req_addr    = {pc[31:2], 2'b00};
                bus_req_byte_en = 4'hF;
                if (bus_req_ready) state_n = FETCH_RESP;
            end
            FETCH_RESP: if (bus_resp_valid) state_n = EXECUTE;
            EXECUTE: begin
                if (mem_op) begin
                    state_n = DATA_REQ;
                end else begin
                    commit  = 1'b1;
                    state_n = FETCH_REQ;
                end
            end
            DATA_REQ: begin
                bus_req_valid   = 1'b1;
                bus_req_write   = is_store;
                bus_req_addr    = data_addr;
                bus_req_byte_en = data_be;
                bus_req_wdata   = data_wdata;
                if (bus_req_ready) state_n = DATA_RESP;
            end
            DATA_RESP: if (bus_resp_valid) state_n = COMMIT;
            COMMIT: begin
                commit  = 1'b1;
                state_n = FETCH_REQ;
            end
`ifdef BUS_TIMEOUT_EN
            HALT: state_n = HALT;
`endif
            default: state_n = FETCH_REQ;
        endcase
`ifdef BUS_TIMEOUT_EN
        if (bus_state && (tmo_cnt == TMO_LAST) && (state_n == state)) state_n = HALT;
`endif
        // Nothing reaches the bus or the datapath while reset is held
        if (!reset) begin
            bus_req_valid   = 1'b0;
            bus_req_write   = 1'b0;
            bus_req_addr    = 32'h0;
            bus_req_wdata   = 32'h0;
            bus_req_byte_en = 4'h0;
            commit          = 1'b0;
        end
    end

    assign pc_write_enable      = commit;
    assign regfile_write_enable = commit & ctl_regfile_write_enable;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state              <= FETCH_REQ;
            inst               <= INITIAL_INST;
            data_mem_read_data <= 32'h0;
            instret            <= 32'h0;
        end else begin
            state <= state_n;
            if (state == FETCH_RESP && bus_resp_valid) inst <= bus_resp_data;
            if (state == DATA_RESP && bus_resp_valid && is_load) data_mem_read_data <= bus_resp_data;
            if (commit) instret <= instret + 32'd1;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state_n != state) tmo_cnt <= '0;
            else if (bus_state)   tmo_cnt <= tmo_cnt + 1'b1;
            if (state_n == HALT && state != HALT) err <= 1'b1;
        end
    end

    assign bus_error = err;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_bus_sequencer.sv
// Directed bench for datapath_bus_sequencer: fetch, ALU commit, stalls, stores, loads, reset abort.
module tb_datapath_bus_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc, data_mem_address, data_mem_write_data;
    logic        ctl_regfile_write_enable, ctl_data_mem_read_enable, ctl_data_mem_write_enable;
    logic [2:0]  ctl_data_mem_format;
    logic [31:0] inst, data_mem_read_data;
    logic        pc_write_enable, regfile_write_enable;
    logic        bus_req_valid, bus_req_ready, bus_req_write;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_byte_en;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        bus_error;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int ncommit = 0;
    int exp_commit = 0;
    logic [31:0] exp_instret = 0;
    logic [31:0] exp_rd = 0;

`ifdef BUS_TIMEOUT_EN
    localparam int STALL = 3;
    datapath_bus_sequencer #(.INITIAL_INST(32'h0000_0013), .TIMEOUT_CYCLES(4)) dut (
`else
    localparam int STALL = 10;
    datapath_bus_sequencer #(.INITIAL_INST(32'h0000_0013)) dut (
`endif
        .clock(clock), .reset(reset), .pc(pc),
        .data_mem_address(data_mem_address), .data_mem_write_data(data_mem_write_data),
        .ctl_regfile_write_enable(ctl_regfile_write_enable),
        .ctl_data_mem_read_enable(ctl_data_mem_read_enable),
        .ctl_data_mem_write_enable(ctl_data_mem_write_enable),
        .ctl_data_mem_format(ctl_data_mem_format),
        .inst(inst), .data_mem_read_data(data_mem_read_data),
        .pc_write_enable(pc_write_enable), .regfile_write_enable(regfile_write_enable),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_byte_en(bus_req_byte_en),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .bus_error(bus_error), .instret(instret)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (pc_write_enable) ncommit <= ncommit + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Entered at a negedge with the sequencer in FETCH_REQ; one-cycle ready and response
    task automatic run_alu(input logic [31:0] iw, input logic rf);
        bus_req_ready = 1'b1;
        cyc();
        chk("fetch_resp_valid_low", {31'b0, bus_req_valid}, 32'd0);
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data = iw;
        ctl_data_mem_read_enable = 1'b0;
        ctl_data_mem_write_enable = 1'b0;
        ctl_regfile_write_enable = rf;
        cyc();
        bus_resp_valid = 1'b0;
        chk("alu_inst", inst, iw);
        chk("alu_pc_we", {31'b0, pc_write_enable}, 32'd1);
        chk("alu_rf_we", {31'b0, regfile_write_enable}, {31'b0, rf});
        exp_instret++;
        exp_commit++;
        pc = pc + 32'd4;
        cyc();
        chk("alu_instret", instret, exp_instret);
        chk("alu_pc_we_done", {31'b0, pc_write_enable}, 32'd0);
        chk("alu_refetch_addr", bus_req_addr, pc);
    endtask

    task automatic run_mem(input string tag, input logic rd, input logic wr, input logic [2:0] fmt,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                           input logic [3:0] exp_be);
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data = 32'h0000_2003;
        ctl_data_mem_read_enable = rd;
        ctl_data_mem_write_enable = wr;
        ctl_data_mem_format = fmt;
        ctl_regfile_write_enable = rd & ~wr;
        data_mem_address = a;
        data_mem_write_data = wd;
        cyc();
        bus_resp_valid = 1'b0;
        chk({tag, "_exec_no_commit"}, {31'b0, pc_write_enable}, 32'd0);
        cyc();
        chk({tag, "_valid"}, {31'b0, bus_req_valid}, 32'd1);
        chk({tag, "_write"}, {31'b0, bus_req_write}, {31'b0, wr});
        chk({tag, "_addr"}, bus_req_addr, exp_addr);
        chk({tag, "_be"}, {28'b0, bus_req_byte_en}, {28'b0, exp_be});
        if (wr) chk({tag, "_wdata"}, bus_req_wdata, exp_wd);
        bus_req_ready = 1'b1;
        cyc();
        chk({tag, "_resp_valid_low"}, {31'b0, bus_req_valid}, 32'd0);
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data = rdata;
        if (rd && !wr) exp_rd = rdata;
        cyc();
        bus_resp_valid = 1'b0;
        chk({tag, "_commit"}, {31'b0, pc_write_enable}, 32'd1);
        chk({tag, "_rf_we"}, {31'b0, regfile_write_enable}, {31'b0, rd & ~wr});
        chk({tag, "_rdata"}, data_mem_read_data, exp_rd);
        exp_instret++;
        exp_commit++;
        pc = pc + 32'd4;
        cyc();
        chk({tag, "_instret"}, instret, exp_instret);
        chk({tag, "_commit_count"}, ncommit, exp_commit);
    endtask

    initial begin
        reset = 1'b0;
        pc = 32'h0000_0100;
        data_mem_address = 32'h0;
        data_mem_write_data = 32'h0;
        ctl_regfile_write_enable = 1'b0;
        ctl_data_mem_read_enable = 1'b0;
        ctl_data_mem_write_enable = 1'b0;
        ctl_data_mem_format = 3'd0;
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_data = 32'h0;
        repeat (3) cyc();
        chk("rst_valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rst_pc_we", {31'b0, pc_write_enable}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_instret", instret, 32'd0);
        chk("rst_rdata", data_mem_read_data, 32'd0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'd0);

        reset = 1'b1;
        cyc();
        chk("first_valid", {31'b0, bus_req_valid}, 32'd1);
        chk("first_addr", bus_req_addr, 32'h0000_0100);
        chk("first_be", {28'b0, bus_req_byte_en}, 32'hF);
        chk("first_write", {31'b0, bus_req_write}, 32'd0);
        chk("first_inst", inst, 32'h0000_0013);

        run_alu(32'h0050_0093, 1'b1);
        run_alu(32'h0000_0013, 1'b0);

        // Request held off: address and valid must not move, nothing commits
        for (int i = 0; i < STALL; i++) begin
            chk("stall_valid", {31'b0, bus_req_valid}, 32'd1);
            chk("stall_addr", bus_req_addr, pc);
            cyc();
        end
        chk("stall_no_commit", ncommit, exp_commit);
        chk("stall_no_error", {31'b0, bus_error}, 32'd0);

        run_mem("sb",    1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h1234_5678,
                32'h0000_1003, 32'hABAB_ABAB, 4'b1000);
        run_mem("sh",    1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'h1234_ABCD, 32'h0,
                32'h0000_1002, 32'hABCD_ABCD, 4'b1100);
        run_mem("sw_mis", 1'b0, 1'b1, 3'd2, 32'h0000_1003, 32'hCAFE_F00D, 32'h0,
                32'h0000_1000, 32'hCAFE_F00D, 4'hF);
        run_mem("lw",    1'b1, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF,
                32'h0000_2000, 32'h0, 4'hF);
        run_mem("rdwr",  1'b1, 1'b1, 3'd2, 32'h0000_3000, 32'h0000_0055, 32'h0BAD_F00D,
                32'h0000_3000, 32'h0000_0055, 4'hF);
        run_mem("lb",    1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h1122_3344,
                32'h0000_2001, 32'h0, 4'hF);

        // Load abandoned by reset in DATA_RESP; the late response must be ignored
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data = 32'h0000_2083;
        ctl_data_mem_read_enable = 1'b1;
        ctl_data_mem_write_enable = 1'b0;
        ctl_data_mem_format = 3'd2;
        data_mem_address = 32'h0000_2000;
        cyc();
        bus_resp_valid = 1'b0;
        cyc();
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        reset = 1'b0;
        cyc();
        chk("abort_valid", {31'b0, bus_req_valid}, 32'd0);
        chk("abort_pc_we", {31'b0, pc_write_enable}, 32'd0);
        chk("abort_instret", instret, 32'd0);
        chk("abort_rdata", data_mem_read_data, 32'd0);
        exp_instret = 0;
        exp_rd = 0;
        reset = 1'b1;
        bus_resp_valid = 1'b1;
        bus_resp_data = 32'hFFFF_FFFF;
        ctl_data_mem_read_enable = 1'b0;
        cyc();
        bus_resp_valid = 1'b0;
        chk("refetch_valid", {31'b0, bus_req_valid}, 32'd1);
        chk("refetch_addr", bus_req_addr, pc);
        chk("refetch_inst", inst, 32'h0000_0013);
        run_alu(32'h0010_0113, 1'b1);
        chk("total_commits", ncommit, exp_commit);

`ifdef BUS_TIMEOUT_EN
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        bus_req_ready = 1'b0;
        repeat (3) cyc();
        chk("tmo_before", {31'b0, bus_error}, 32'd0);
        chk("tmo_before_valid", {31'b0, bus_req_valid}, 32'd1);
        cyc();
        chk("tmo_error", {31'b0, bus_error}, 32'd1);
        chk("tmo_valid", {31'b0, bus_req_valid}, 32'd0);
        bus_req_ready = 1'b1;
        bus_resp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("halt_valid", {31'b0, bus_req_valid}, 32'd0);
            chk("halt_pc_we", {31'b0, pc_write_enable}, 32'd0);
        end
        chk("halt_error_sticky", {31'b0, bus_error}, 32'd1);
        chk("halt_commits", ncommit, exp_commit);
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
